controlador_de_sessao: RTL and testbench

CONTROLADOR_DE_SESSAO -- requirements
Module: controlador_de_sessao

---
 rtl/controlador_de_sessao_pkg.sv | 13 +
 rtl/controlador_de_sessao_detector_de_borda.sv | 20 ++
 rtl/controlador_de_sessao.sv | 80 ++++++++
 tb/tb_controlador_de_sessao.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/controlador_de_sessao_pkg.sv
// controlador_de_sessao_pkg: shared states, valid user codes and timing defaults for the session controller
package controlador_de_sessao_pkg;
  typedef enum logic [1:0] {OCIOSO, USUARIO, ATIVO, ERRO} estado_t;
  localparam int TIMEOUT_PADRAO = 15;
  localparam int ERRO_TICKS_PADRAO = 3;
  localparam logic [2:0] USR_A = 3'b001;
  localparam logic [2:0] USR_B = 3'b011;
  localparam logic [2:0] USR_C = 3'b101;
  localparam logic [2:0] USR_D = 3'b110;
  function automatic logic usuario_valido(input logic [2:0] sw);
    return sw inside {USR_A, USR_B, USR_C, USR_D};
  endfunction
endpackage

// File: rtl/controlador_de_sessao_detector_de_borda.sv
// detector_de_borda: one-cycle press pulse on a rising level, suppressed on the first edge after reset
module detector_de_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);
  logic r_prev;
  logic r_armado;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_prev   <= 1'b0;
      r_armado <= 1'b0;
    end else begin
      r_prev   <= i_btn;
      r_armado <= 1'b1;
    end
  // a button held through reset release must not look like a fresh press
  assign o_press = i_btn & ~r_prev & r_armado;
endmodule

// File: rtl/controlador_de_sessao.sv
// controlador_de_sessao: login/function session FSM with inactivity timeout and timed error state
module controlador_de_sessao
  import controlador_de_sessao_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_PADRAO,
  parameter int ERRO_TICKS = ERRO_TICKS_PADRAO
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] Sw,
  input  logic       Confirma,
  input  logic       Sair,
  input  logic       Tick,
  output logic [2:0] User,
  output logic [2:0] Func,
  output logic       Ativo,
  output logic       Erro
);
  estado_t    r_estado, w_prox;
  logic [2:0] r_user, r_func, w_user, w_func;
  logic [3:0] r_cnt, w_cnt;
  logic [2:0] r_out_user, r_out_func;
  logic       r_ativo, r_erro;
  logic       w_conf, w_sair;
  detector_de_borda u_conf (.clk(clk), .rst_n(rst_n), .i_btn(Confirma), .o_press(w_conf));
  detector_de_borda u_sair (.clk(clk), .rst_n(rst_n), .i_btn(Sair), .o_press(w_sair));
  always_comb begin
    w_prox = r_estado;
    w_user = r_user;
    w_func = r_func;
    w_cnt  = r_cnt;
    case (r_estado)
      OCIOSO: if (w_conf) begin
        w_prox = usuario_valido(Sw) ? USUARIO : ERRO;
        w_user = usuario_valido(Sw) ? Sw : 3'b000;
      end
      USUARIO, ATIVO:
        if (w_sair) w_prox = OCIOSO;
        else if (w_conf && Sw != 3'b000) begin
          w_prox = ATIVO;
          w_func = Sw;
          w_cnt  = 4'd0;
        end else if (Tick) begin
          w_cnt  = r_cnt + 4'd1;
          w_prox = (w_cnt == 4'(TIMEOUT)) ? OCIOSO : r_estado;
        end
      ERRO: if (Tick) begin
        w_cnt  = r_cnt + 4'd1;
        w_prox = (w_cnt == 4'(ERRO_TICKS)) ? OCIOSO : ERRO;
      end
    endcase
    w_cnt  = (w_prox != r_estado) ? 4'd0 : w_cnt;
    w_user = (w_prox == OCIOSO) ? 3'b000 : w_user;
    w_func = (w_prox == OCIOSO) ? 3'b000 : w_func;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_estado   <= OCIOSO;
      r_user     <= 3'b000;
      r_func     <= 3'b000;
      r_cnt      <= 4'd0;
      r_out_user <= 3'b000;
      r_out_func <= 3'b000;
      r_ativo    <= 1'b0;
      r_erro     <= 1'b0;
    end else begin
      r_estado   <= w_prox;
      r_user     <= w_user;
      r_func     <= w_func;
      r_cnt      <= w_cnt;
      r_out_user <= (w_prox == ATIVO) ? w_user : 3'b000;
      r_out_func <= (w_prox == ATIVO) ? w_func : 3'b000;
      r_ativo    <= w_prox == ATIVO;
      r_erro     <= w_prox == ERRO;
    end
  assign User  = r_out_user;
  assign Func  = r_out_func;
  assign Ativo = r_ativo;
  assign Erro  = r_erro;
endmodule

// File: tb/tb_controlador_de_sessao.sv
// tb_controlador_de_sessao: directed scenarios plus randomized traffic against a session-level model
module tb_controlador_de_sessao;
  localparam int TO = 15;
  localparam int ET = 3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] Sw = 3'b000;
  logic       Confirma = 1'b0, Sair = 1'b0, Tick = 1'b0;
  logic [2:0] User, Func;
  logic       Ativo, Erro;
  controlador_de_sessao dut (
    .clk(clk), .rst_n(rst_n), .Sw(Sw), .Confirma(Confirma), .Sair(Sair), .Tick(Tick),
    .User(User), .Func(Func), .Ativo(Ativo), .Erro(Erro)
  );
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  // session-level model: who is logged in, which function is chosen, error countdown, idle ticks
  bit       m_hu, m_hf, m_pc, m_ps, m_armed;
  bit [2:0] m_user, m_func;
  int       m_err, m_idle;
  wire [7:0] obs = {User, Func, Ativo, Erro};
  function automatic void m_clear();
    m_hu = 0; m_hf = 0; m_user = 0; m_func = 0; m_idle = 0;
  endfunction
  function automatic void m_reset();
    m_clear();
    m_err = 0; m_pc = 0; m_ps = 0; m_armed = 0;
  endfunction
  function automatic void m_step(input bit [2:0] sw, input bit c, input bit s, input bit t);
    bit pc, ps;
    pc = c && !m_pc && m_armed;
    ps = s && !m_ps && m_armed;
    m_pc = c; m_ps = s; m_armed = 1;
    if (m_err > 0) begin
      if (t) m_err--;
    end else if (!m_hu) begin
      if (pc) begin
        if (sw == 3'd1 || sw == 3'd3 || sw == 3'd5 || sw == 3'd6) begin
          m_hu = 1; m_user = sw; m_idle = 0;
        end else m_err = ET;
      end
    end else if (ps) m_clear();
    else if (pc && sw != 3'd0) begin
      m_hf = 1; m_func = sw; m_idle = 0;
    end else if (t) begin
      m_idle++;
      if (m_idle == TO) m_clear();
    end
  endfunction
  function automatic logic [7:0] exp_out();
    return m_hf ? {m_user, m_func, 2'b10} : {7'b0, m_err > 0};
  endfunction
  task automatic cycle(input logic [2:0] sw, input logic c, input logic s, input logic t);
    Sw = sw; Confirma = c; Sair = s; Tick = t;
    @(posedge clk);
    m_step(sw, c, s, t);
    #1;
  endtask
  task automatic login(input logic [2:0] u, input logic [2:0] f);
    cycle(u, 1, 0, 0); cycle(u, 0, 0, 0);
    cycle(f, 1, 0, 0); cycle(f, 0, 0, 0);
  endtask
  task automatic test_reset();
    rst_n = 0; m_reset();
    @(posedge clk); #2;
    n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL reset obs=%b exp=%b", obs, 8'h00); end
    @(negedge clk); rst_n = 1;
    cycle(0, 0, 0, 0);
    n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL reset_release obs=%b exp=%b", obs, 8'h00); end
  endtask
  task automatic test_login_func();
    cycle(3'b101, 1, 0, 0);
    n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL login_user obs=%b exp=%b", obs, 8'h00); end
    cycle(3'b101, 0, 0, 0);
    cycle(3'b000, 1, 0, 0); cycle(3'b000, 0, 0, 0);
    n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL func_zero_ignored obs=%b exp=%b", obs, 8'h00); end
    cycle(3'b111, 1, 0, 0);
    n_tests++; if (obs !== 8'b101_111_1_0) begin n_fail++; $display("FAIL login_func obs=%b exp=%b", obs, 8'b101_111_1_0); end
    cycle(3'b000, 0, 0, 0); cycle(3'b000, 1, 0, 0);
    n_tests++; if (obs !== 8'b101_111_1_0) begin n_fail++; $display("FAIL ativo_zero_ignored obs=%b exp=%b", obs, 8'b101_111_1_0); end
    cycle(3'b000, 0, 1, 0);
    n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL sair obs=%b exp=%b", obs, 8'h00); end
    cycle(3'b000, 0, 0, 0);
  endtask
  task automatic test_erro();
    cycle(3'b010, 1, 0, 0);
    n_tests++; if (obs !== 8'h01) begin n_fail++; $display("FAIL erro_enter obs=%b exp=%b", obs, 8'h01); end
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 0); cycle(0, 0, 0, 1);
    n_tests++; if (obs !== 8'h01) begin n_fail++; $display("FAIL erro_2ticks obs=%b exp=%b", obs, 8'h01); end
    cycle(3'b001, 1, 1, 0);
    n_tests++; if (obs !== 8'h01) begin n_fail++; $display("FAIL erro_press obs=%b exp=%b", obs, 8'h01); end
    cycle(0, 0, 0, 1);
    n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL erro_exit obs=%b exp=%b", obs, 8'h00); end
  endtask
  task automatic test_timeout();
    login(3'b011, 3'b100);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 1);
    n_tests++; if (obs !== 8'b011_100_1_0) begin n_fail++; $display("FAIL timeout_14 obs=%b exp=%b", obs, 8'b011_100_1_0); end
    cycle(0, 0, 0, 1);
    n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL timeout_15 obs=%b exp=%b", obs, 8'h00); end
    login(3'b011, 3'b100);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 1);
    cycle(3'b110, 1, 0, 1);
    n_tests++; if (obs !== 8'b011_110_1_0) begin n_fail++; $display("FAIL press_tick obs=%b exp=%b", obs, 8'b011_110_1_0); end
    cycle(0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 1);
    n_tests++; if (obs !== 8'b011_110_1_0) begin n_fail++; $display("FAIL restart_14 obs=%b exp=%b", obs, 8'b011_110_1_0); end
    cycle(0, 0, 0, 1);
    n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL restart_15 obs=%b exp=%b", obs, 8'h00); end
  endtask
  task automatic test_sair_conf();
    login(3'b001, 3'b110);
    n_tests++; if (obs !== 8'b001_110_1_0) begin n_fail++; $display("FAIL sc_login obs=%b exp=%b", obs, 8'b001_110_1_0); end
    cycle(3'b001, 1, 1, 0);
    n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL sair_wins obs=%b exp=%b", obs, 8'h00); end
    cycle(0, 0, 0, 0);
  endtask
  task automatic test_held();
    for (int i = 0; i < 10; i++) begin
      cycle(3'b001, 1, 0, 0);
      n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL held_%0d obs=%b exp=%b", i, obs, 8'h00); end
    end
    cycle(3'b010, 0, 0, 0); cycle(3'b010, 1, 0, 0);
    n_tests++; if (obs !== 8'b001_010_1_0) begin n_fail++; $display("FAIL held_func obs=%b exp=%b", obs, 8'b001_010_1_0); end
    cycle(0, 0, 1, 0); cycle(0, 0, 0, 0);
  endtask
  task automatic test_async_reset();
    login(3'b001, 3'b110);
    n_tests++; if (obs !== 8'b001_110_1_0) begin n_fail++; $display("FAIL ar_login obs=%b exp=%b", obs, 8'b001_110_1_0); end
    Sw = 3'b001; Confirma = 1;
    #1 rst_n = 0; m_reset();
    #1;
    n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL async_reset obs=%b exp=%b", obs, 8'h00); end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) cycle(3'b001, 1, 0, 0);
    cycle(3'b111, 0, 0, 0); cycle(3'b111, 1, 0, 0);
    n_tests++; if (obs !== 8'h01) begin n_fail++; $display("FAIL held_through_reset obs=%b exp=%b", obs, 8'h01); end
    for (int i = 0; i < ET; i++) cycle(0, 0, 0, 1);
    n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL ar_erro_exit obs=%b exp=%b", obs, 8'h00); end
  endtask
  task automatic test_random();
    int rate;
    rate = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) rate = $urandom_range(0, 4);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0; m_reset(); #2;
        n_tests++; if (obs !== 8'h00) begin n_fail++; $display("FAIL rnd_reset i=%0d obs=%b exp=%b", i, obs, 8'h00); end
        @(negedge clk); rst_n = 1;
      end else begin
        cycle(3'($urandom_range(0, 7)), $urandom_range(0, 19) < rate,
              $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 3);
        n_tests++;
        if (obs !== exp_out()) begin n_fail++; $display("FAIL rnd i=%0d obs=%b exp=%b", i, obs, exp_out()); end
      end
    end
  endtask
  initial begin
    m_reset();
    test_reset();
    test_login_func();
    test_erro();
    test_timeout();
    test_sair_conf();
    test_held();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
